tx_frame_sched: RTL

- Schedules frames from two TX queue FIFOs into the tx_cgmii datapath.
- Round-robin arbitration between queues, then generates the rts start pulse.
- Paces tx_dvld/fifo_rd beats at the rate set by the active speed mode.
- Enforces an inter-frame idle gap; drops frames with illegal length without transmitting them.

---
 rtl/tx_sched_if.sv | 26 ++
 rtl/tx_frame_sched.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/tx_sched_if.sv
// Queue-side and tx_cgmii-side signals of the TX frame scheduler.
// master = scheduler, slave = queue FIFOs / tx_cgmii datapath.
interface tx_sched_if;
  logic        q0_req;
  logic        q1_req;
  logic [15:0] q0_len;
  logic [15:0] q1_len;
  logic [1:0]  q_grant;
  logic        fifo_rd;
  logic        rts;
  logic        tx_dvld;
  logic [1:0]  q_done;
  logic [15:0] pkt_len;
  logic        len_err;
  logic        busy;

  modport master (
    input  q0_req, q1_req, q0_len, q1_len,
    output q_grant, fifo_rd, rts, tx_dvld, q_done, pkt_len, len_err, busy
  );

  modport slave (
    output q0_req, q1_req, q0_len, q1_len,
    input  q_grant, fifo_rd, rts, tx_dvld, q_done, pkt_len, len_err, busy
  );
endinterface

// File: rtl/tx_frame_sched.sv
// Round-robin two-queue TX frame scheduler with speed-mode beat pacing, IPG and bad-length drop.
// Optional per-queue/drop statistics counters are compiled in with TX_SCHED_STATS_EN.
module tx_frame_sched #(
  parameter int IPG_BEATS = 1,
  parameter int MIN_BYTES = 64,
  parameter int MAX_BYTES = 9600
) (
  input  logic        clk156,
  input  logic        rst,
  input  logic        mode_100G,
  input  logic        mode_50G,
  input  logic        mode_40G,
  input  logic        mode_25G,
  input  logic        sched_en,
`ifdef TX_SCHED_STATS_EN
  input  logic        stats_clr,
  output logic [31:0] q0_frm_cnt,
  output logic [31:0] q1_frm_cnt,
  output logic [31:0] drop_cnt,
`endif
  tx_sched_if.master  bus
);

  typedef enum logic [2:0] {IDLE, ARB, START, DATA, DROP, DONE, GAP} state_t;

  localparam logic [15:0] MIN_L = 16'(MIN_BYTES);
  localparam logic [15:0] MAX_L = 16'(MAX_BYTES);
  localparam logic [5:0]  IPG_L = 6'(IPG_BEATS);

  state_t      state;
  logic        last_q1;   // queue served last; reset value lets q0 win the first tie
  logic        owner;
  logic [11:0] nb;
  logic [1:0]  pm1;       // beat period minus one, frozen for the whole frame
  logic [1:0]  phase;
  logic [5:0]  gap_cnt;

  logic        pick_q1;
  logic [15:0] sel_len;
  logic [11:0] nb_init;
  logic [1:0]  mode_pm1;
  logic [5:0]  gap_len;
  logic        len_ok;

  always_comb begin
    pick_q1 = bus.q1_req && (!bus.q0_req || !last_q1);
    sel_len = pick_q1 ? bus.q1_len : bus.q0_len;
    nb_init = 12'((17'(sel_len) + 17'd31) >> 5);
    len_ok  = (bus.pkt_len >= MIN_L) && (bus.pkt_len <= MAX_L);

    mode_pm1 = 2'd3;
    if (mode_100G)                 mode_pm1 = 2'd0;
    else if (mode_50G || mode_40G) mode_pm1 = 2'd1;
    else if (mode_25G)             mode_pm1 = 2'd3;

    case (pm1)
      2'd1:    gap_len = IPG_L << 1;
      2'd3:    gap_len = IPG_L << 2;
      default: gap_len = IPG_L;
    endcase
  end

  always_ff @(posedge clk156) begin
    if (rst) begin
      state       <= IDLE;
      last_q1     <= 1'b1;
      owner       <= 1'b0;
      nb          <= '0;
      pm1         <= '0;
      phase       <= '0;
      gap_cnt     <= '0;
      bus.q_grant <= '0;
      bus.fifo_rd <= 1'b0;
      bus.rts     <= 1'b0;
      bus.tx_dvld <= 1'b0;
      bus.q_done  <= '0;
      bus.pkt_len <= '0;
      bus.len_err <= 1'b0;
      bus.busy    <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low here and are raised below only in the cycle they belong to.
      bus.rts     <= 1'b0;
      bus.q_done  <= '0;
      bus.len_err <= 1'b0;

      case (state)
        IDLE: begin
          if (sched_en && (bus.q0_req || bus.q1_req)) begin
            owner       <= pick_q1;
            last_q1     <= pick_q1;
            bus.q_grant <= pick_q1 ? 2'b10 : 2'b01;
            bus.pkt_len <= sel_len;
            nb          <= nb_init;
            bus.busy    <= 1'b1;
            state       <= ARB;
          end
        end

        ARB: begin
          pm1   <= mode_pm1;
          phase <= '0;
          if (len_ok) begin
            bus.rts <= 1'b1;
            state   <= START;
          end else begin
            bus.len_err <= 1'b1;
            bus.fifo_rd <= (nb != 12'd0);
            state       <= DROP;
          end
        end

        START: begin
          bus.fifo_rd <= 1'b1;
          bus.tx_dvld <= 1'b1;
          state       <= DATA;
        end

        DATA: begin
          if (bus.fifo_rd) nb <= nb - 12'd1;
          if (bus.fifo_rd && nb == 12'd1) begin
            bus.fifo_rd <= 1'b0;
            bus.tx_dvld <= 1'b0;
            bus.q_grant <= '0;
            bus.q_done  <= owner ? 2'b10 : 2'b01;
            state       <= DONE;
          end else if (phase == pm1) begin
            bus.fifo_rd <= 1'b1;
            bus.tx_dvld <= 1'b1;
            phase       <= '0;
          end else begin
            bus.fifo_rd <= 1'b0;
            bus.tx_dvld <= 1'b0;
            phase       <= phase + 2'd1;
          end
        end

        DROP: begin
          if (bus.fifo_rd && nb != 12'd1) begin
            nb <= nb - 12'd1;
          end else begin
            bus.fifo_rd <= 1'b0;
            bus.q_grant <= '0;
            bus.q_done  <= owner ? 2'b10 : 2'b01;
            state       <= DONE;
          end
        end

        DONE: begin
          if (IPG_BEATS == 0) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else begin
            gap_cnt <= gap_len - 6'd1;
            state   <= GAP;
          end
        end

        GAP: begin
          if (gap_cnt == 6'd0) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 6'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef TX_SCHED_STATS_EN
  logic drop_pend;  // marks the frame in flight as dropped until its q_done

  always_ff @(posedge clk156) begin
    if (rst) begin
      drop_pend <= 1'b0;
    end else if (bus.len_err) begin
      drop_pend <= 1'b1;
    end else if (|bus.q_done) begin
      drop_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk156) begin
    if (rst || stats_clr) begin
      q0_frm_cnt <= '0;
      q1_frm_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      if (bus.q_done[0] && !drop_pend) q0_frm_cnt <= q0_frm_cnt + 32'd1;
      if (bus.q_done[1] && !drop_pend) q1_frm_cnt <= q1_frm_cnt + 32'd1;
      if (bus.len_err)                 drop_cnt   <= drop_cnt + 32'd1;
    end
  end
`endif

endmodule
